// File: rtl/instr_ctrl_pkg.sv
// instr_ctrl_pkg: shared constants and types for the host instruction
// controller.
//   - instruction/field widths and bit positions of the 71-bit word
//   - opcode constants and a legality helper
//   - FSM state encoding
package instr_ctrl_pkg;

  localparam int INSTR_W = 71;
  localparam int ADDR_W  = 16;
  localparam int DIM_W   = 8;
  localparam int MODE_W  = 4;
  localparam int OP_W    = 3;

  // Field bit positions inside the instruction word
  localparam int OP_MSB   = 70;
  localparam int OP_LSB   = 68;
  localparam int A_MSB    = 67;
  localparam int A_LSB    = 52;
  localparam int B_MSB    = 51;
  localparam int B_LSB    = 36;
  localparam int O_MSB    = 35;
  localparam int O_LSB    = 20;
  localparam int M_MSB    = 19;
  localparam int M_LSB    = 12;
  localparam int K_MSB    = 11;
  localparam int K_LSB    = 4;
  localparam int MODE_MSB = 3;
  localparam int MODE_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
  localparam logic [OP_W-1:0] OP_CONFIG = 3'd1;
  localparam logic [OP_W-1:0] OP_RUN    = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACK      = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_LAUNCH   = 3'd3,
    ST_BUSY     = 3'd4
  } state_t;

  // True for the three defined opcodes
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_CONFIG, OP_RUN: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_ctrl_if.sv
// instr_ctrl_if: host instruction handshake.
//   instr_valid : host -> controller, word valid
//   instr       : host -> controller, INSTR_W-bit instruction
//   ack         : controller -> host, one-cycle acceptance pulse
// master = host side, slave = controller side.
interface instr_ctrl_if;
  import instr_ctrl_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               ack;

  modport master (output instr_valid, output instr, input ack);
  modport slave  (input instr_valid, input instr, output ack);

endinterface

// File: rtl/instr_ctrl_decode.sv
// instr_decode: purely combinational split of an instruction word into its
// fields plus an opcode legality flag.
//   instr_i  : instruction word
//   op_o     : opcode
//   a/b/o_base_o, m_o, k_o, mode_o : CONFIG payload fields
//   legal_o  : opcode is NOP, CONFIG or RUN
module instr_decode
  import instr_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [OP_W-1:0]    op_o,
  output logic [ADDR_W-1:0]  a_base_o,
  output logic [ADDR_W-1:0]  b_base_o,
  output logic [ADDR_W-1:0]  o_base_o,
  output logic [DIM_W-1:0]   m_o,
  output logic [DIM_W-1:0]   k_o,
  output logic [MODE_W-1:0]  mode_o,
  output logic               legal_o
);

  assign op_o     = instr_i[OP_MSB:OP_LSB];
  assign a_base_o = instr_i[A_MSB:A_LSB];
  assign b_base_o = instr_i[B_MSB:B_LSB];
  assign o_base_o = instr_i[O_MSB:O_LSB];
  assign m_o      = instr_i[M_MSB:M_LSB];
  assign k_o      = instr_i[K_MSB:K_LSB];
  assign mode_o   = instr_i[MODE_MSB:MODE_LSB];
  assign legal_o  = op_is_legal(op_o);

endmodule

// File: rtl/instr_ctrl.sv
// instr_ctrl: responder for host instructions of the accelerator.
// Accepts instructions on the host interface, acks them for one cycle,
// latches CONFIG fields and sequences RUN: wait for both global buffers,
// pulse start, wait for eng_done, raise sticky done.
//   clk, rst         : clock, asynchronous active-low reset
//   host (slave)     : instr_valid / instr / ack handshake
//   A_ready, B_ready : global buffers loaded
//   eng_done         : engine finished pulse
//   start, done, err : launch pulse, sticky complete, sticky illegal opcode
//   cfg_*            : configuration registers
// Optional macro INSTR_PERF_CNT_EN adds perf_instr / perf_cycles counters.
module instr_ctrl
  import instr_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  instr_ctrl_if.slave       host,
  input  logic              A_ready,
  input  logic              B_ready,
  input  logic              eng_done,
  output logic              done,
  output logic              start,
  output logic [ADDR_W-1:0] cfg_a_base,
  output logic [ADDR_W-1:0] cfg_b_base,
  output logic [ADDR_W-1:0] cfg_o_base,
  output logic [DIM_W-1:0]  cfg_m,
  output logic [DIM_W-1:0]  cfg_k,
  output logic [MODE_W-1:0] cfg_mode,
  output logic              err
`ifdef INSTR_PERF_CNT_EN
  ,
  output logic [15:0]       perf_instr,
  output logic [31:0]       perf_cycles
`endif
);

  logic [OP_W-1:0]   dec_op_s;
  logic [ADDR_W-1:0] dec_a_s, dec_b_s, dec_o_s;
  logic [DIM_W-1:0]  dec_m_s, dec_k_s;
  logic [MODE_W-1:0] dec_mode_s;
  logic              dec_legal_s;

  instr_decode u_decode (
    .instr_i  (host.instr),
    .op_o     (dec_op_s),
    .a_base_o (dec_a_s),
    .b_base_o (dec_b_s),
    .o_base_o (dec_o_s),
    .m_o      (dec_m_s),
    .k_o      (dec_k_s),
    .mode_o   (dec_mode_s),
    .legal_o  (dec_legal_s)
  );

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic              ack_q, ack_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, o_base_q, o_base_d;
  logic [DIM_W-1:0]  m_q, m_d, k_q, k_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              accept_s;

  assign accept_s = (state_q == ST_IDLE) && host.instr_valid && armed_q;

  // Next-state, command decode and output pulse generation
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    ack_d    = 1'b0;
    start_d  = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    op_d     = op_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    o_base_d = o_base_q;
    m_d      = m_q;
    k_d      = k_q;
    mode_d   = mode_q;

    // A host holding valid high stays disarmed until it drops valid once
    if (!host.instr_valid) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          armed_d = 1'b0;
          op_d    = dec_op_s;
          if (!dec_legal_s) begin
            err_d = 1'b1;
          end else begin
            case (dec_op_s)
              OP_CONFIG: begin
                a_base_d = dec_a_s;
                b_base_d = dec_b_s;
                o_base_d = dec_o_s;
                m_d      = dec_m_s;
                k_d      = dec_k_s;
                mode_d   = dec_mode_s;
              end
              OP_RUN:  done_d = 1'b0;
              default: done_d = done_q;
            endcase
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (op_q == OP_RUN) begin
          // An empty problem completes without touching the engine
          if ((m_q == 8'd0) || (k_q == 8'd0)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_RDY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RDY: begin
        if (A_ready && B_ready) begin
          state_d = ST_LAUNCH;
          start_d = 1'b1;
        end else begin
          state_d = ST_WAIT_RDY;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (eng_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      armed_q  <= 1'b1;
      ack_q    <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      op_q     <= OP_NOP;
      a_base_q <= 16'd0;
      b_base_q <= 16'd0;
      o_base_q <= 16'd0;
      m_q      <= 8'd0;
      k_q      <= 8'd0;
      mode_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      ack_q    <= ack_d;
      start_q  <= start_d;
      done_q   <= done_d;
      err_q    <= err_d;
      op_q     <= op_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      o_base_q <= o_base_d;
      m_q      <= m_d;
      k_q      <= k_d;
      mode_q   <= mode_d;
    end
  end

  assign host.ack   = ack_q;
  assign start      = start_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cfg_a_base = a_base_q;
  assign cfg_b_base = b_base_q;
  assign cfg_o_base = o_base_q;
  assign cfg_m      = m_q;
  assign cfg_k      = k_q;
  assign cfg_mode   = mode_q;

`ifdef INSTR_PERF_CNT_EN
  logic [15:0] perf_instr_q;
  logic [31:0] perf_cycles_q;
  logic        run_phase_s;

  assign run_phase_s = (state_q == ST_WAIT_RDY) || (state_q == ST_LAUNCH) ||
                       (state_q == ST_BUSY);

  // Accepted-instruction counter (wraps) and run-cycle counter (saturates)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_instr_q  <= 16'd0;
      perf_cycles_q <= 32'd0;
    end else begin
      if (accept_s) begin
        perf_instr_q <= perf_instr_q + 16'd1;
      end else begin
        perf_instr_q <= perf_instr_q;
      end
      if (run_phase_s && (perf_cycles_q != 32'hFFFF_FFFF)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end else begin
        perf_cycles_q <= perf_cycles_q;
      end
    end
  end

  assign perf_instr  = perf_instr_q;
  assign perf_cycles = perf_cycles_q;
`endif

endmodule
